// File: rtl/sbqm_pkg.sv
//------------------------------------------------------------------------------
// sbqm_pkg: shared widths, wait-time FSM states and occupancy helpers. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sbqm_pkg;

  localparam int CNT_W_DEF        = 3;
  localparam int TCNT_W_DEF       = 2;
  localparam int SERVICE_T_DEF    = 3;
  localparam int WT_W_DEF         = 5;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DEBOUNCE_CYC_DEF = 4;

  function automatic int max_count(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int MAX_COUNT = max_count(CNT_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } wt_state_e;

endpackage

`default_nettype wire

// File: rtl/sensor_debounce.sv
//------------------------------------------------------------------------------
// sensor_debounce: synchroniser, debounce filter and rising-edge pulse. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sensor_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   lvl_prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Level flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (synced != lvl_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        lvl_d = synced;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= (sync_q << 1) | SYNC_STAGES'(raw_i);
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

`default_nettype wire

// File: rtl/queue_flow_controller.sv
//------------------------------------------------------------------------------
// queue_flow_controller: occupancy count, full/empty flags, wait-time divider. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module queue_flow_controller
  import sbqm_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TCNT_W       = TCNT_W_DEF,
  parameter int SERVICE_T    = SERVICE_T_DEF,
  parameter int WT_W         = WT_W_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              back_sensor,
  input  logic              front_sensor,
  input  logic [TCNT_W-1:0] teller_cnt,
  output logic [CNT_W-1:0]  pcount,
  output logic              full,
  output logic              empty,
  output logic              arr_drop,
  output logic              dep_drop,
  output logic [WT_W-1:0]   wtime,
  output logic              wtime_valid
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(max_count(CNT_W));

  logic arr_evt, dep_evt;

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_back (
    .clk(clk), .reset(reset), .raw_i(back_sensor), .rise_o(arr_evt)
  );

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_front (
    .clk(clk), .reset(reset), .raw_i(front_sensor), .rise_o(dep_evt)
  );

  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             arr_drop_q, arr_drop_d, dep_drop_q, dep_drop_d;

  // Simultaneous arrival and departure at empty: admit the arrival, reject the departure.
  always_comb begin
    pcount_d   = pcount_q;
    arr_drop_d = 1'b0;
    dep_drop_d = 1'b0;
    case ({arr_evt, dep_evt})
      2'b10: if (pcount_q == MAX_C) arr_drop_d = 1'b1;
             else                   pcount_d   = pcount_q + CNT_W'(1);
      2'b01: if (pcount_q == '0)    dep_drop_d = 1'b1;
             else                   pcount_d   = pcount_q - CNT_W'(1);
      2'b11: if (pcount_q == '0) begin
               pcount_d   = CNT_W'(1);
               dep_drop_d = 1'b1;
             end
      default: ;
    endcase
    full_d  = (pcount_d == MAX_C);
    empty_d = (pcount_d == '0);
  end

  wt_state_e         state_q, state_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic [TCNT_W-1:0] t_q, t_d;
  logic [WT_W-1:0]   num_q, num_d, quo_q, quo_d, wtime_q, wtime_d;
  logic              valid_q, valid_d;
  logic              trig;

  assign trig = (pcount_q != p_q) || (teller_cnt != t_q);

  // Any trigger, in any state, resamples the inputs and restarts at LOAD.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    num_d   = num_q;
    quo_d   = quo_q;
    wtime_d = wtime_q;
    valid_d = valid_q;
    if (trig) begin
      p_d     = pcount_q;
      t_d     = teller_cnt;
      valid_d = 1'b0;
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (t_q == '0) begin
            wtime_d = '1;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            num_d   = (p_q == '0) ? '0 :
                      WT_W'(SERVICE_T) * (WT_W'(p_q) + WT_W'(t_q) - WT_W'(1));
            quo_d   = '0;
            state_d = DIV;
          end
        end
        DIV: begin
          if (num_q >= WT_W'(t_q)) begin
            num_d = num_q - WT_W'(t_q);
            quo_d = quo_q + WT_W'(1);
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          wtime_d = quo_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcount_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      arr_drop_q <= 1'b0;
      dep_drop_q <= 1'b0;
      state_q    <= IDLE;
      p_q        <= '0;
      t_q        <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      wtime_q    <= '0;
      valid_q    <= 1'b1;
    end else begin
      pcount_q   <= pcount_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      arr_drop_q <= arr_drop_d;
      dep_drop_q <= dep_drop_d;
      state_q    <= state_d;
      p_q        <= p_d;
      t_q        <= t_d;
      num_q      <= num_d;
      quo_q      <= quo_d;
      wtime_q    <= wtime_d;
      valid_q    <= valid_d;
    end
  end

  assign pcount      = pcount_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign arr_drop    = arr_drop_q;
  assign dep_drop    = dep_drop_q;
  assign wtime       = wtime_q;
  assign wtime_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_queue_flow_controller.sv
//------------------------------------------------------------------------------
// tb_queue_flow_controller: directed and random stimulus against a behavioural model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_queue_flow_controller;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int HL = S + D;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       back_sensor = 1'b0;
  logic       front_sensor = 1'b0;
  logic [1:0] teller_cnt = 2'd1;
  logic [2:0] pcount;
  logic       full, empty, arr_drop, dep_drop;
  logic [4:0] wtime;
  logic       wtime_valid;

  int vectors = 0;
  int miscompares = 0;
  int arr_drops = 0;
  int dep_drops = 0;

  always #5 clk = ~clk;

  queue_flow_controller dut (
    .clk(clk), .reset(reset), .back_sensor(back_sensor), .front_sensor(front_sensor),
    .teller_cnt(teller_cnt), .pcount(pcount), .full(full), .empty(empty),
    .arr_drop(arr_drop), .dep_drop(dep_drop), .wtime(wtime), .wtime_valid(wtime_valid)
  );

  // Behavioural model: raw-sample history filter, occupancy rules, wait-time job with latency.
  logic [HL-1:0] hb, hf;
  logic          lb, lf, eb, ef;
  logic [2:0]    m_pcount;
  logic          m_arr_drop, m_dep_drop, m_valid;
  logic [4:0]    m_wtime, job_res;
  logic [2:0]    job_p;
  logic [1:0]    job_t;
  int            remaining;
  int            num;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb = '0; hf = '0; lb = 0; lf = 0; eb = 0; ef = 0;
      m_pcount = 0; m_arr_drop = 0; m_dep_drop = 0;
      m_wtime = 0; m_valid = 1; job_p = 0; job_t = 0; remaining = 0; job_res = 0;
    end else begin
      if (m_pcount != job_p || teller_cnt != job_t) begin
        job_p = m_pcount;
        job_t = teller_cnt;
        m_valid = 0;
        if (job_t == 0) begin
          job_res = 5'd31;
          remaining = 1;
        end else begin
          num = (job_p == 0) ? 0 : 3 * (int'(job_p) + int'(job_t) - 1);
          job_res = 5'(num / int'(job_t));
          remaining = num / int'(job_t) + 3;
        end
      end else if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_wtime = job_res;
          m_valid = 1;
        end
      end
      m_arr_drop = 0;
      m_dep_drop = 0;
      case ({eb, ef})
        2'b10: if (m_pcount == 7) m_arr_drop = 1; else m_pcount = m_pcount + 1;
        2'b01: if (m_pcount == 0) m_dep_drop = 1; else m_pcount = m_pcount - 1;
        2'b11: if (m_pcount == 0) begin m_pcount = 1; m_dep_drop = 1; end
        default: ;
      endcase
      hb = {hb[HL-2:0], back_sensor};
      hf = {hf[HL-2:0], front_sensor};
      eb = 0;
      ef = 0;
      if (hb[HL-1:S] == {D{~lb}}) begin lb = ~lb; eb = lb; end
      if (hf[HL-1:S] == {D{~lf}}) begin lf = ~lf; ef = lf; end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (arr_drop) arr_drops++;
    if (dep_drop) dep_drops++;
    if (pcount !== m_pcount || full !== (m_pcount == 7) || empty !== (m_pcount == 0) ||
        arr_drop !== m_arr_drop || dep_drop !== m_dep_drop ||
        wtime !== m_wtime || wtime_valid !== m_valid) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got pcount=%0d full=%0b empty=%0b ad=%0b dd=%0b wt=%0d v=%0b; expected %0d %0b %0b %0b %0b %0d %0b",
               $time, pcount, full, empty, arr_drop, dep_drop, wtime, wtime_valid,
               m_pcount, m_pcount == 7, m_pcount == 0, m_arr_drop, m_dep_drop, m_wtime, m_valid);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit b, input bit f, input int len);
    @(negedge clk);
    back_sensor = b;
    front_sensor = f;
    repeat (len) @(negedge clk);
    back_sensor = 0;
    front_sensor = 0;
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("rst_pcount", int'(pcount), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wtime", int'(wtime), 0);
    chk("rst_valid", int'(wtime_valid), 1);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int a0;
    repeat (3) @(negedge clk);
    chk("init_pcount", int'(pcount), 0);
    chk("init_empty", int'(empty), 1);
    reset = 1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 5; i++) pulse(1, 0, 6);
    chk("five_arrivals", int'(pcount), 5);
    do_reset();

    repeat (40) @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      pulse(1, 0, 6);
      chk("arrival_count", int'(pcount), i);
    end
    chk("full_at_7", int'(full), 1);
    a0 = arr_drops;
    pulse(1, 0, 6);
    chk("arr_drop_pulses", arr_drops - a0, 1);
    chk("hold_at_7", int'(pcount), 7);

    do_reset();
    a0 = dep_drops;
    pulse(0, 1, 6);
    chk("dep_drop_pulses", dep_drops - a0, 1);
    chk("hold_at_0", int'(pcount), 0);
    pulse(1, 0, 2);
    chk("glitch_ignored", int'(pcount), 0);

    for (int i = 0; i < 3; i++) pulse(1, 0, 6);
    pulse(1, 1, 6);
    chk("both_at_3", int'(pcount), 3);
    do_reset();
    a0 = dep_drops;
    pulse(1, 1, 6);
    chk("both_at_0", int'(pcount), 1);
    chk("both_at_0_drop", dep_drops - a0, 1);
    for (int i = 0; i < 6; i++) pulse(1, 0, 6);
    pulse(1, 1, 6);
    chk("both_at_7", int'(pcount), 7);

    do_reset();
    teller_cnt = 2'd2;
    for (int i = 0; i < 5; i++) pulse(1, 0, 6);
    repeat (40) @(negedge clk);
    chk("wt_p5_t2", int'(wtime), 9);
    pulse(1, 0, 6);
    pulse(1, 0, 6);
    teller_cnt = 2'd3;
    @(negedge clk);
    chk("valid_low_busy", int'(wtime_valid), 0);
    repeat (40) @(negedge clk);
    chk("wt_p7_t3", int'(wtime), 9);
    teller_cnt = 2'd1;
    repeat (6) @(negedge clk);
    teller_cnt = 2'd3;
    repeat (40) @(negedge clk);
    chk("wt_restart", int'(wtime), 9);
    chk("wt_restart_valid", int'(wtime_valid), 1);
    do_reset();
    teller_cnt = 2'd1;
    pulse(1, 0, 6);
    repeat (40) @(negedge clk);
    chk("wt_p1_t1", int'(wtime), 3);
    teller_cnt = 2'd0;
    repeat (10) @(negedge clk);
    chk("wt_t0", int'(wtime), 31);

    for (int i = 0; i < 400; i++) begin
      back_sensor = 1'($urandom_range(0, 1));
      front_sensor = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) teller_cnt = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 9)) @(negedge clk);
    end
    back_sensor = 0;
    front_sensor = 0;
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
